// File: rtl/sprite_bounce_engine.sv
// sprite_bounce_engine: draws a SPR_W x SPR_H sprite, waits a number of frames,
// erases it, moves it one STEP per axis and bounces it off the screen edges.
//
// Handshake: go is a level input sampled only in IDLE and MOVE. plot is a
// write strobe that qualifies x, y and colour_out in the same cycle, with no
// back-pressure. move_done pulses for one cycle right after each MOVE.
module sprite_bounce_engine #(
    parameter int          SCREEN_W        = 160,
    parameter int          SCREEN_H        = 120,
    parameter int          SPR_W           = 4,
    parameter int          SPR_H           = 4,
    parameter int          STEP            = 1,
    parameter int          TICKS_PER_FRAME = 833333,
    parameter int          FRAMES_PER_MOVE = 15,
    parameter logic [2:0]  ERASE_COLOUR    = 3'b000
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       go,
    input  logic       pause,
    input  logic [2:0] colour,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour_out,
    output logic       plot,
    output logic       busy,
    output logic       move_done,
    output logic [2:0] state_dbg
);

    localparam int OXW = $clog2(SPR_W + 1);
    localparam int OYW = $clog2(SPR_H + 1);
    localparam int TW  = (TICKS_PER_FRAME > 1) ? $clog2(TICKS_PER_FRAME) : 1;
    localparam int FW  = $clog2(FRAMES_PER_MOVE + 1);

    // Edge limits and step, one bit wider than the position so nothing wraps.
    localparam logic [8:0] XMAX_W = 9'(SCREEN_W - SPR_W);
    localparam logic [7:0] YMAX_W = 8'(SCREEN_H - SPR_H);
    localparam logic [8:0] STEP_XW = 9'(STEP);
    localparam logic [7:0] STEP_YW = 8'(STEP);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_DRAW  = 3'd1,
        S_WAIT  = 3'd2,
        S_ERASE = 3'd3,
        S_MOVE  = 3'd4
    } state_t;

    state_t           state_q, state_d;
    logic [OXW-1:0]   ox_q, ox_d;
    logic [OYW-1:0]   oy_q, oy_d;
    logic [TW-1:0]    tick_q, tick_d;
    logic [FW-1:0]    frame_q, frame_d;
    logic [7:0]       pos_x_q, pos_x_d;
    logic [6:0]       pos_y_q, pos_y_d;
    logic             dir_x_q, dir_x_d;   // 0 = right, 1 = left
    logic             dir_y_q, dir_y_d;   // 0 = down,  1 = up
    logic [2:0]       spr_col_q, spr_col_d;

    logic [7:0]       x_q, x_d;
    logic [6:0]       y_q, y_d;
    logic [2:0]       col_out_q, col_out_d;
    logic             plot_q, plot_d;
    logic             busy_q, busy_d;
    logic             md_q, md_d;

    logic [8:0]       sum_x;
    logic [7:0]       sum_y;
    logic             last_col, last_row;
    logic             scan_d;

    assign sum_x    = {1'b0, pos_x_q} + STEP_XW;
    assign sum_y    = {1'b0, pos_y_q} + STEP_YW;
    assign last_col = (ox_q == OXW'(SPR_W - 1));
    assign last_row = (oy_q == OYW'(SPR_H - 1));

    // Next-state logic: scan counters, frame timing and the bounce arithmetic.
    always_comb begin
        state_d   = state_q;
        ox_d      = ox_q;
        oy_d      = oy_q;
        tick_d    = tick_q;
        frame_d   = frame_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        dir_x_d   = dir_x_q;
        dir_y_d   = dir_y_q;
        spr_col_d = spr_col_q;
        case (state_q)
            S_IDLE: begin
                if (go) begin
                    state_d   = S_DRAW;
                    spr_col_d = colour;
                    ox_d      = '0;
                    oy_d      = '0;
                end
            end
            S_DRAW, S_ERASE: begin
                if (last_col) begin
                    ox_d = '0;
                    if (last_row) begin
                        oy_d = '0;
                        if (state_q == S_DRAW) begin
                            state_d = S_WAIT;
                            tick_d  = '0;
                            frame_d = '0;
                        end else begin
                            state_d = S_MOVE;
                        end
                    end else begin
                        oy_d = oy_q + OYW'(1);
                    end
                end else begin
                    ox_d = ox_q + OXW'(1);
                end
            end
            S_WAIT: begin
                if (!pause) begin
                    if (tick_q == TW'(TICKS_PER_FRAME - 1)) begin
                        tick_d  = '0;
                        frame_d = frame_q + FW'(1);
                        if (frame_q + FW'(1) == FW'(FRAMES_PER_MOVE)) begin
                            state_d = S_ERASE;
                            ox_d    = '0;
                            oy_d    = '0;
                        end
                    end else begin
                        tick_d = tick_q + TW'(1);
                    end
                end
            end
            S_MOVE: begin
                if (!dir_x_q) begin
                    if (sum_x >= XMAX_W) begin
                        pos_x_d = XMAX_W[7:0];
                        dir_x_d = 1'b1;
                    end else begin
                        pos_x_d = sum_x[7:0];
                    end
                end else if ({1'b0, pos_x_q} <= STEP_XW) begin
                    pos_x_d = '0;
                    dir_x_d = 1'b0;
                end else begin
                    pos_x_d = pos_x_q - STEP_XW[7:0];
                end
                if (!dir_y_q) begin
                    if (sum_y >= YMAX_W) begin
                        pos_y_d = YMAX_W[6:0];
                        dir_y_d = 1'b1;
                    end else begin
                        pos_y_d = sum_y[6:0];
                    end
                end else if ({1'b0, pos_y_q} <= STEP_YW) begin
                    pos_y_d = '0;
                    dir_y_d = 1'b0;
                end else begin
                    pos_y_d = pos_y_q - STEP_YW[6:0];
                end
                if (go) begin
                    state_d   = S_DRAW;
                    spr_col_d = colour;
                    ox_d      = '0;
                    oy_d      = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state so the
    // registered outputs line up with the state they describe.
    always_comb begin
        scan_d    = (state_d == S_DRAW) || (state_d == S_ERASE);
        x_d       = scan_d ? pos_x_d + 8'(ox_d) : pos_x_d;
        y_d       = scan_d ? pos_y_d + 7'(oy_d) : pos_y_d;
        col_out_d = (state_d == S_DRAW)  ? spr_col_d :
                    (state_d == S_ERASE) ? ERASE_COLOUR : 3'b000;
        plot_d    = scan_d;
        busy_d    = (state_d != S_IDLE);
        md_d      = (state_q == S_MOVE);
    end

    // State, datapath and registered outputs; reset is immediate.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            ox_q      <= '0;
            oy_q      <= '0;
            tick_q    <= '0;
            frame_q   <= '0;
            pos_x_q   <= '0;
            pos_y_q   <= '0;
            dir_x_q   <= 1'b0;
            dir_y_q   <= 1'b0;
            spr_col_q <= '0;
            x_q       <= '0;
            y_q       <= '0;
            col_out_q <= '0;
            plot_q    <= 1'b0;
            busy_q    <= 1'b0;
            md_q      <= 1'b0;
        end else begin
            state_q   <= state_d;
            ox_q      <= ox_d;
            oy_q      <= oy_d;
            tick_q    <= tick_d;
            frame_q   <= frame_d;
            pos_x_q   <= pos_x_d;
            pos_y_q   <= pos_y_d;
            dir_x_q   <= dir_x_d;
            dir_y_q   <= dir_y_d;
            spr_col_q <= spr_col_d;
            x_q       <= x_d;
            y_q       <= y_d;
            col_out_q <= col_out_d;
            plot_q    <= plot_d;
            busy_q    <= busy_d;
            md_q      <= md_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour_out = col_out_q;
    assign plot       = plot_q;
    assign busy       = busy_q;
    assign move_done  = md_q;
    assign state_dbg  = state_q;

endmodule
